branch_redirect_ctrl: RTL

//  Resolves one control-transfer instruction per handshake in EX: branch, JAL or JALR.

---
 rtl/branch_pkg.sv | 19 +
 rtl/branch_resolve.sv | 45 ++++
 rtl/branch_redirect_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared types for the EX-stage control-transfer resolve and redirect logic.
package branch_pkg;

    typedef enum logic [1:0] {
        BR_NONE   = 2'd0,
        BR_BRANCH = 2'd1,
        BR_JAL    = 2'd2,
        BR_JALR   = 2'd3
    } br_type_e;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REDIRECT = 2'd1,
        S_DRAIN    = 2'd2
    } state_e;

    localparam int INST_BYTES = 4;

endpackage

// File: rtl/branch_resolve.sv
// Combinational resolve of one control-transfer op: taken, target, next PC, mispredict, misalign.
// Zero latency; no state, so no backpressure of its own.
module branch_resolve
    import branch_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [1:0]            br_type,
    input  logic                  br_cond,
    input  logic [ADDR_WIDTH-1:0] ex_pc,
    input  logic                  pred_taken,
    input  logic [ADDR_WIDTH-1:0] pred_target,
    input  logic [ADDR_WIDTH-1:0] bra_addr,
    input  logic [ADDR_WIDTH-1:0] jal_addr,
    input  logic [ADDR_WIDTH-1:0] jalr_addr,
    output logic                  taken,
    output logic [ADDR_WIDTH-1:0] target,
    output logic [ADDR_WIDTH-1:0] next_pc,
    output logic                  mispred,
    output logic                  misalign
);

    always_comb begin
        taken  = 1'b1;
        target = jal_addr;
        case (br_type)
            BR_BRANCH: begin
                taken  = br_cond;
                target = bra_addr;
            end
            BR_JAL:  target = jal_addr;
            BR_JALR: target = jalr_addr;
            default: begin
                taken  = 1'b0;
                target = ex_pc;
            end
        endcase
    end

    // Fall-through wraps naturally at 2^ADDR_WIDTH.
    assign next_pc  = taken ? target : ex_pc + ADDR_WIDTH'(INST_BYTES);
    assign mispred  = (taken != pred_taken) | (taken & (target != pred_target));
    assign misalign = taken & target[1];

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Resolves EX control transfers; on mispredict holds a redirect to fetch, flushes IF/ID, then drains.
// Resolve is same-cycle as accept; redirect/flush/misalign appear the following cycle.
// ex_ready drops while a redirect is pending or draining; redirect is held until redirect_ready.
module branch_redirect_ctrl
    import branch_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int INST_WIDTH   = 32,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [ADDR_WIDTH-1:0] ex_pc,
    input  logic [1:0]            br_type,
    input  logic                  br_cond,
    input  logic                  pred_taken,
    input  logic [ADDR_WIDTH-1:0] pred_target,
    input  logic [ADDR_WIDTH-1:0] bra_addr,
    input  logic [ADDR_WIDTH-1:0] jal_addr,
    input  logic [ADDR_WIDTH-1:0] jalr_addr,
    input  logic                  kill,
    output logic                  redirect_valid,
    input  logic                  redirect_ready,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  flush_if_id,
    output logic                  misalign_exc,
    output logic [ADDR_WIDTH-1:0] misalign_addr,
    output logic [CNT_WIDTH-1:0]  resolve_cnt,
    output logic [CNT_WIDTH-1:0]  mispred_cnt
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    if (DRAIN_CYCLES < 1 || INST_WIDTH != 8 * INST_BYTES) begin : g_param_check
        $error("branch_redirect_ctrl: unsupported DRAIN_CYCLES or INST_WIDTH");
    end

    state_e                state_q, state_d;
    logic [DW-1:0]         drain_cnt_q, drain_cnt_d;
    logic [ADDR_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
    logic                  flush_q, flush_d;
    logic                  misalign_q, misalign_d;
    logic [ADDR_WIDTH-1:0] misalign_addr_q, misalign_addr_d;
    logic [CNT_WIDTH-1:0]  resolve_cnt_q, resolve_cnt_d;
    logic [CNT_WIDTH-1:0]  mispred_cnt_q, mispred_cnt_d;

    logic                  res_taken;
    logic [ADDR_WIDTH-1:0] res_target;
    logic [ADDR_WIDTH-1:0] res_next_pc;
    logic                  res_mispred;
    logic                  res_misalign;
    logic                  op_acc;

    branch_resolve #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_resolve (
        .br_type     (br_type),
        .br_cond     (br_cond),
        .ex_pc       (ex_pc),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .bra_addr    (bra_addr),
        .jal_addr    (jal_addr),
        .jalr_addr   (jalr_addr),
        .taken       (res_taken),
        .target      (res_target),
        .next_pc     (res_next_pc),
        .mispred     (res_mispred),
        .misalign    (res_misalign)
    );

    assign ex_ready = (state_q == S_IDLE) & ~kill;
    // NONE ops are swallowed by the handshake but never resolved or counted.
    assign op_acc   = ex_valid & ex_ready & (br_type != BR_NONE);

    always_comb begin
        state_d         = state_q;
        drain_cnt_d     = drain_cnt_q;
        redirect_pc_d   = redirect_pc_q;
        flush_d         = 1'b0;
        misalign_d      = 1'b0;
        misalign_addr_d = misalign_addr_q;
        resolve_cnt_d   = resolve_cnt_q;
        mispred_cnt_d   = mispred_cnt_q;

        if (kill) begin
            state_d     = S_IDLE;
            drain_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (op_acc) begin
                        if (~&resolve_cnt_q) resolve_cnt_d = resolve_cnt_q + 1'b1;
                        // A misaligned taken target traps instead of redirecting.
                        if (res_misalign) begin
                            misalign_d      = 1'b1;
                            misalign_addr_d = res_target;
                        end else if (res_mispred) begin
                            state_d       = S_REDIRECT;
                            redirect_pc_d = res_next_pc;
                            flush_d       = 1'b1;
                            if (~&mispred_cnt_q) mispred_cnt_d = mispred_cnt_q + 1'b1;
                        end
                    end
                end
                S_REDIRECT: begin
                    if (redirect_ready) begin
                        state_d     = S_DRAIN;
                        drain_cnt_d = DW'(DRAIN_CYCLES - 1);
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        drain_cnt_d = drain_cnt_q - 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            drain_cnt_q     <= '0;
            redirect_pc_q   <= '0;
            flush_q         <= 1'b0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
            resolve_cnt_q   <= '0;
            mispred_cnt_q   <= '0;
        end else begin
            state_q         <= state_d;
            drain_cnt_q     <= drain_cnt_d;
            redirect_pc_q   <= redirect_pc_d;
            flush_q         <= flush_d;
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
            resolve_cnt_q   <= resolve_cnt_d;
            mispred_cnt_q   <= mispred_cnt_d;
        end
    end

    assign redirect_valid = (state_q == S_REDIRECT);
    assign redirect_pc    = redirect_pc_q;
    assign flush_if_id    = flush_q;
    assign misalign_exc   = misalign_q;
    assign misalign_addr  = misalign_addr_q;
    assign resolve_cnt    = resolve_cnt_q;
    assign mispred_cnt    = mispred_cnt_q;

endmodule
